// File: rtl/xtea_core.sv
// XTEA block-cipher engine: one Feistel half-round per clock, encrypt or decrypt per operation,
// with a start/ready/done handshake and a configurable number of cycles.
module xtea_core #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         decrypt,
  input  logic [31:0]  data_in1,
  input  logic [31:0]  data_in2,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic [31:0]  data_out1,
  output logic [31:0]  data_out2,
  output logic         done
);

  localparam logic [31:0] DecSum    = DELTA * ROUNDS;
  localparam logic [7:0]  LastRound = 8'(ROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StHalfA, StHalfB, StFinish} state_e;

  state_e        state_q, state_d;
  logic [31:0]   w0_q, w0_d, w1_q, w1_d, sum_q, sum_d;
  logic [31:0]   out1_q, out1_d, out2_q, out2_d;
  logic [127:0]  key_q, key_d;
  logic [7:0]    r_q, r_d;
  logic          dec_q, dec_d, done_q, done_d;
  logic [31:0]   sub_lo, sub_hi;

  function automatic logic [31:0] mix(logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  function automatic logic [31:0] key_word(logic [127:0] k, logic [1:0] idx);
    case (idx)
      2'd0:    return k[127:96];
      2'd1:    return k[95:64];
      2'd2:    return k[63:32];
      default: return k[31:0];
    endcase
  endfunction

  // Round subkeys selected by the low and high sum bits respectively.
  assign sub_lo = sum_q + key_word(key_q, sum_q[1:0]);
  assign sub_hi = sum_q + key_word(key_q, sum_q[12:11]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StHalfA;
      StHalfA:  state_d = StHalfB;
      StHalfB:  state_d = (r_q == LastRound) ? StFinish : StHalfA;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == StIdle);
  end

  always_comb begin
    w0_d   = w0_q;
    w1_d   = w1_q;
    sum_d  = sum_q;
    key_d  = key_q;
    r_d    = r_q;
    dec_d  = dec_q;
    out1_d = out1_q;
    out2_d = out2_q;
    done_d = (state_q == StFinish);
    case (state_q)
      StIdle: begin
        if (start) begin
          w0_d  = data_in1;
          w1_d  = data_in2;
          key_d = key_in;
          dec_d = decrypt;
          r_d   = 8'd0;
          sum_d = decrypt ? DecSum : 32'd0;
        end
      end
      StHalfA: begin
        if (dec_q) begin
          w1_d  = w1_q - (mix(w0_q) ^ sub_hi);
          sum_d = sum_q - DELTA;
        end else begin
          w0_d  = w0_q + (mix(w1_q) ^ sub_lo);
          sum_d = sum_q + DELTA;
        end
      end
      StHalfB: begin
        r_d = r_q + 8'd1;
        if (dec_q) begin
          w0_d = w0_q - (mix(w1_q) ^ sub_lo);
        end else begin
          w1_d = w1_q + (mix(w0_q) ^ sub_hi);
        end
      end
      StFinish: begin
        out1_d = w0_q;
        out2_d = w1_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w0_q   <= '0;
      w1_q   <= '0;
      sum_q  <= '0;
      key_q  <= '0;
      r_q    <= '0;
      dec_q  <= 1'b0;
      out1_q <= '0;
      out2_q <= '0;
      done_q <= 1'b0;
    end else begin
      w0_q   <= w0_d;
      w1_q   <= w1_d;
      sum_q  <= sum_d;
      key_q  <= key_d;
      r_q    <= r_d;
      dec_q  <= dec_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
      done_q <= done_d;
    end
  end

  assign data_out1 = out1_q;
  assign data_out2 = out2_q;
  assign done      = done_q;

endmodule
